// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Uses one shift-add or restoring-subtract step per cycle (32 cycles per op); divide-by-zero and overflow finish in one cycle.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata1_i,
  input  logic [31:0] rdata2_i,
  input  logic [4:0]  regs_rd_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  regs_rd_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [4:0]  cnt_r;
  logic [2:0]  funct3_r;
  logic [4:0]  rd_r;
  logic [31:0] opb_r;
  logic [63:0] prod_r;
  logic        neg_r;

  logic        accept_s, special_s, div_zero_s, div_ovf_s;
  logic        a_neg_s, b_neg_s, neg_s;
  logic [31:0] a_mag_s, b_mag_s, special_res_s, final_s;
  logic [32:0] mul_sum_s, div_shift_s, div_diff_s;
  logic [63:0] prod_step_s;

  function automatic logic [31:0] negate32(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

  // Select the architectural result from the unsigned magnitude result and sign flag.
  function automatic logic [31:0] apply_sign(input logic [2:0] f3, input logic neg, input logic [63:0] p);
    logic [63:0] full;
    full = neg ? (64'd0 - p) : p;
    case (f3)
      3'b000:                 return full[31:0];
      3'b001, 3'b010, 3'b011: return full[63:32];
      3'b100, 3'b101:         return neg ? negate32(p[31:0]) : p[31:0];
      3'b110, 3'b111:         return neg ? negate32(p[63:32]) : p[63:32];
      default:                return 32'd0;
    endcase
  endfunction

  // Operand magnitudes, sign bookkeeping and special-case detection at acceptance.
  always_comb begin
    a_neg_s  = rdata1_i[31] && (funct3_i != 3'b011) && (funct3_i != 3'b101) && (funct3_i != 3'b111);
    b_neg_s  = rdata2_i[31] && (funct3_i != 3'b010) && (funct3_i != 3'b011) &&
               (funct3_i != 3'b101) && (funct3_i != 3'b111);
    a_mag_s  = a_neg_s ? negate32(rdata1_i) : rdata1_i;
    b_mag_s  = b_neg_s ? negate32(rdata2_i) : rdata2_i;
    neg_s    = (funct3_i == 3'b110) ? a_neg_s : (a_neg_s ^ b_neg_s);
    accept_s = start_i && !flush_i && ((state_r == IDLE) || (state_r == DONE));
    div_zero_s = funct3_i[2] && (rdata2_i == 32'd0);
    div_ovf_s  = funct3_i[2] && !funct3_i[0] && (rdata1_i == 32'h8000_0000) && (rdata2_i == 32'hFFFF_FFFF);
    special_s  = div_zero_s || div_ovf_s;
    if (div_zero_s) begin
      special_res_s = funct3_i[1] ? rdata1_i : 32'hFFFF_FFFF;
    end else begin
      special_res_s = funct3_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum_s   = {1'b0, prod_r[63:32]} + (prod_r[0] ? {1'b0, opb_r} : 33'd0);
    div_shift_s = prod_r[63:31];
    div_diff_s  = div_shift_s - {1'b0, opb_r};
    if (!funct3_r[2]) begin
      prod_step_s = {mul_sum_s, prod_r[31:1]};
    end else if (div_diff_s[32]) begin
      prod_step_s = {div_shift_s[31:0], prod_r[30:0], 1'b0};
    end else begin
      prod_step_s = {div_diff_s[31:0], prod_r[30:0], 1'b1};
    end
    final_s = apply_sign(funct3_r, neg_r, prod_step_s);
  end

  // Next-state logic and the combinational stall request.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = accept_s ? (special_s ? DONE : CALC) : IDLE;
      CALC:    state_s = (cnt_r == 5'd31) ? DONE : CALC;
      DONE:    state_s = accept_s ? (special_s ? DONE : CALC) : IDLE;
      default: state_s = IDLE;
    endcase
    if (flush_i) begin
      state_s = IDLE;
    end else begin
      state_s = state_s;
    end
    busy_o = rst_n && !flush_i &&
             (((state_r == IDLE) && start_i) || (state_r == CALC) || ((state_r == DONE) && start_i));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Operand latching, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r     <= 5'd0;
      funct3_r  <= 3'd0;
      rd_r      <= 5'd0;
      opb_r     <= 32'd0;
      prod_r    <= 64'd0;
      neg_r     <= 1'b0;
      valid_o   <= 1'b0;
      result_o  <= 32'd0;
      regs_rd_o <= 5'd0;
    end else begin
      valid_o <= 1'b0;
      if (accept_s) begin
        funct3_r <= funct3_i;
        rd_r     <= regs_rd_i;
        neg_r    <= neg_s;
        cnt_r    <= 5'd0;
        // Multiply keeps the multiplier in the low half; divide shifts the dividend out of it.
        prod_r   <= {32'd0, funct3_i[2] ? a_mag_s : b_mag_s};
        opb_r    <= funct3_i[2] ? b_mag_s : a_mag_s;
        if (special_s) begin
          valid_o   <= 1'b1;
          result_o  <= special_res_s;
          regs_rd_o <= regs_rd_i;
        end
      end else if ((state_r == CALC) && !flush_i) begin
        prod_r <= prod_step_s;
        cnt_r  <= cnt_r + 5'd1;
        if (cnt_r == 5'd31) begin
          valid_o   <= 1'b1;
          result_o  <= final_s;
          regs_rd_o <= rd_r;
        end
      end
    end
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-low (clk, rst_n).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start_i  input  1  request: execute the RV32M operation carried in the ID/EX stage outputs.
REQ-005 funct3_i  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rdata1_i  input  32  rs1 operand.
REQ-007 rdata2_i  input  32  rs2 operand.
REQ-008 regs_rd_i  input  5  destination register index.
REQ-009 flush_i  input  1  abort the current operation.
REQ-010 busy_o  output  1  pipeline stall request.
REQ-011 valid_o  output  1  result_o and regs_rd_o are valid this cycle.
REQ-012 result_o  output  32  operation result.
REQ-013 regs_rd_o  output  5  destination index latched at acceptance.

Function
REQ-014 The block SHALL implement the states IDLE, CALC and DONE.
REQ-015 IDLE with start_i=1 and flush_i=0 SHALL accept the request: latch funct3, operands and rd.
- Normal case: go to CALC and clear the counter.
- Special case (REQ-021, REQ-022): go directly to DONE.
REQ-016 CALC SHALL run for exactly 32 cycles: one shift-add (multiply) or one restoring-subtract (divide) step per cycle; the counter increments 0..31 and the state goes to DONE after step 31.
REQ-017 DONE SHALL last one cycle with valid_o=1.
- Next state is CALC or DONE (per REQ-015) if start_i=1 and flush_i=0 (back-to-back accept).
- Otherwise next state is IDLE.
REQ-018 Latency: request accepted at edge N gives valid_o=1 in cycle N+33 (normal) or N+1 (special case).
REQ-019 busy_o SHALL be combinational: busy_o = (IDLE and start_i) or CALC or (DONE and start_i); busy_o=0 whenever flush_i=1.
REQ-020 Signed operations SHALL work on operand magnitudes and apply the result sign at DONE.
- MULH: rs1 and rs2 signed.
- MULHSU: rs1 signed, rs2 unsigned.
- MULHU, DIVU, REMU: unsigned.
- The product is 64 bits. MUL returns [31:0]; the MULH variants return [63:32].
- DIV: quotient sign = sign(rs1) XOR sign(rs2).
- REM: remainder sign = sign(rs1).
REQ-021 Divide by zero (rs2=0) SHALL be a special case.
- DIV and DIVU return 0xFFFFFFFF.
- REM and REMU return rs1.
REQ-022 Signed overflow (DIV or REM with rs1=0x80000000 and rs2=0xFFFFFFFF) SHALL be a special case: DIV returns 0x80000000 and REM returns 0.
REQ-023 start_i SHALL be ignored while in CALC.
REQ-024 flush_i=1 SHALL force the next state to IDLE from any state, take priority over start_i, and suppress valid_o in the following cycle.
REQ-025 result_o and regs_rd_o SHALL hold their last DONE values until the next DONE; valid_o SHALL be 0 outside DONE.

Reset
REQ-026 With rst_n=0 at a rising edge, the block SHALL enter IDLE, clear the counter and set valid_o=0, result_o=0, regs_rd_o=0 and all internal operand and accumulator registers to 0.
REQ-027 With rst_n=0, busy_o SHALL be 0; rst_n=0 during CALC SHALL abort the operation with no valid_o pulse.
REQ-028 Reset SHALL take priority over start_i and flush_i.

Verification
REQ-029 MUL: rs1=7, rs2=-3 (0xFFFFFFFD), rd=5 -> busy_o high for 33 cycles; valid_o at N+33 with result_o=0xFFFFFFEB and regs_rd_o=5.
REQ-030 MULH/MULHU: rs1=rs2=0x80000000 -> MULH result_o=0x40000000; MULHU result_o=0x40000000; MULHSU result_o=0xC0000000.
REQ-031 Division: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/16 -> 0x0FFFFFFF; REMU -> 0xF.
REQ-032 Special cases: DIV x/0 and DIV 0x80000000/-1 -> valid_o at N+1 with values per REQ-021 and REQ-022; REMU 123/0 -> 123.
REQ-033 flush_i pulse at cycle N+10 of a DIV -> no valid_o; next IDLE start_i accepted normally; results match the golden model.
REQ-034 rst_n=0 mid-CALC, then a back-to-back start_i asserted in DONE -> no stale valid_o; the second result arrives 33 cycles after the first DONE.
